prog_mem_loader: RTL and testbench
==================================

// Module: prog_mem_loader
// PURPOSE
// - Writable program memory for the VGA/keyboard CPU; parametrised successor to the fixed instruction store.
// - Serves instruction fetch via a registered read port.
// - Accepts a runtime byte-stream loader (keyboard/serial front end) that assembles bytes into words and commits them.
// - Asserts oHold so the CPU freezes its PC while a load is in progress.
// PARAMETERS
// - ADDR_WIDTH  8   address bits of storage; DEPTH = 2**ADDR_WIDTH words
// - INSN_WIDTH  28  instruction width; NBYTES = ceil(INSN_WIDTH/8) (localparam, 4 at default)
// PORTS
// - Clock        in   1           single clock, rising edge
// - Reset        in   1           asynchronous, active-low
// - iAddress     in   16          CPU fetch address
// - oInstruction out  INSN_WIDTH  registered fetch data
// - iLoadStart   in   1           pulse: begin load at iLoadBase
// - iLoadBase    in   ADDR_WIDTH  first word address of load
// - iLoadValid   in   1           iLoadByte valid
// - iLoadByte    in   8           stream byte, MSB-first within word
// - iLoadLast    in   1           qualifies final byte of stream
// - oLoadReady   out  1           byte accepted when iLoadValid & oLoadReady at edge
// - oHold        out  1           1 while state != IDLE; CPU stalls PC
// - oLoadDone    out  1           1-cycle pulse at end of load
// - oLoadErr     out  1           sticky until next iLoadStart: partial word or overflow
// - oLoadCount   out  ADDR_WIDTH+1  words committed in current/last load
// BEHAVIOUR
// - Reset values: oInstruction = NOP_WORD ({`NOP,24'd4000}); all other outputs 0; state IDLE; load pointer 0.
// - Reset does not clear the storage array. Reset mid-load drops the partial word; already-committed words are kept.
// - Fetch: oInstruction(N+1) = mem[iAddress(N)], 1-cycle latency.
//   - iAddress >= DEPTH -> NOP_WORD.
//   - oHold=1 -> NOP_WORD.
// - Read-before-write: a fetch and a commit to the same address in the same cycle return the old word.
// - FSM IDLE -> LOAD -> COMMIT:
//   - IDLE: oLoadReady=0; bytes ignored. iLoadStart: ptr<=iLoadBase, byte idx<=0, oLoadCount<=0, oLoadErr<=0, go LOAD.
//   - LOAD: oLoadReady=1; each accepted byte shifts into the assembly register, idx++. On byte NBYTES-1 go COMMIT.
//   - LOAD, iLoadLast with idx < NBYTES-1: partial word discarded, oLoadErr=1, oLoadDone pulse, go IDLE.
//   - COMMIT (1 cycle, oLoadReady=0): mem[ptr] <= low INSN_WIDTH bits of assembled bytes (upper bits of the first byte ignored); ptr++, oLoadCount++.
//     Then go IDLE (with oLoadDone pulse) if the last byte carried iLoadLast, else back to LOAD.
// - Overflow: commit when ptr has passed DEPTH-1 (ptr held as ADDR_WIDTH+1 bits, no wrap).
//   - The word is dropped and oLoadErr=1.
//   - Streaming continues: bytes are still accepted and drained until iLoadLast.
// - iLoadStart while in LOAD/COMMIT restarts the load: a pending COMMIT completes first, then re-init as from IDLE.
// - iLoadValid and iLoadLast are only sampled when the handshake occurs.
// CONFIGURATION
// - PROGMEM_PARITY_EN defined:
//   - Each word stores one extra even-parity bit, computed at COMMIT.
//   - Fetch with parity mismatch -> oInstruction=NOP_WORD, oParityErr (extra output port, 1 bit) sets, sticky until Reset.
// - PROGMEM_PARITY_EN undefined: no parity bit, no oParityErr port; array is INSN_WIDTH wide.
// STRUCTURE
// - Shared package (Definitions.v): `NOP opcode, NOP_WORD, default INSN_WIDTH, loader FSM state encodings.
// - Sub-module prog_mem_assembler: byte shift register, idx counter and word-complete strobe.
// - Top level holds the FSM, pointer, storage array and fetch register.
// TESTING
// - Reset low -> oInstruction=NOP_WORD, oHold=0, oLoadReady=0, oLoadCount=0.
// - Start at base 5; bytes 0x0A,0xBC,0xDE,0xF0, then 0x01,0x23,0x45,0x67 (with iLoadLast):
//   - mem[5]=28'hABCDEF0, mem[6]=28'h1234567.
//   - oLoadDone pulses once; oLoadCount=2; fetch 6 returns 28'h1234567 one cycle later.
// - iAddress=16'h0100 (ADDR_WIDTH=8) -> NOP_WORD; iAddress=5 during oHold=1 -> NOP_WORD.
// - Start at base 9; 2 bytes then iLoadLast -> oLoadErr=1, mem[9] unchanged, oLoadCount=0.
// - Start at base 255; 2 full words -> mem[255] written; second word dropped; oLoadErr=1; oLoadCount=1.
// - Reset asserted after 2 bytes of a word -> state IDLE, mem[base] unchanged; previously committed words intact.
// - PROGMEM_PARITY_EN: force-flip one array bit of mem[5], fetch 5 -> NOP_WORD, oParityErr=1.

Source files
------------

// File: rtl/prog_mem_loader_pkg.sv
// Shared definitions for the writable program memory: NOP encoding, loader states, parity helper.
package prog_mem_loader_pkg;

  localparam int INSN_WIDTH_DEF = 28;
  localparam logic [3:0]  NOP_OP   = 4'h0;
  localparam logic [27:0] NOP_WORD = {NOP_OP, 24'd4000};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } load_state_e;

  // Reduction XOR; a zero result means the word (plus its parity bit) has even parity.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/prog_mem_loader_assembler.sv
// Byte-to-word assembler: MSB-first shift register with byte index and word-complete strobe.
module prog_mem_assembler #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic [7:0]            din,
  output logic [NBYTES*8-1:0]   word,
  output logic                  complete
);

  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  logic [NBYTES*8-1:0] word_r;
  logic [IDXW-1:0]     idx_r;

  // Shift accepted bytes in from the right; index wraps after the final byte of a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r <= '0;
      idx_r  <= '0;
    end else if (clear) begin
      word_r <= '0;
      idx_r  <= '0;
    end else if (shift_en) begin
      word_r <= (NBYTES*8)'({word_r, din});
      idx_r  <= (idx_r == LAST_IDX) ? '0 : idx_r + IDXW'(1);
    end
  end

  assign word     = word_r;
  assign complete = shift_en & (idx_r == LAST_IDX);

endmodule

// File: rtl/prog_mem_loader.sv
// Writable program memory with registered fetch port and byte-stream loader.
// Optional build macro PROGMEM_PARITY_EN adds a stored even-parity bit and the oParityErr output.
module prog_mem_loader
  import prog_mem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int INSN_WIDTH = INSN_WIDTH_DEF
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [15:0]           iAddress,
  output logic [INSN_WIDTH-1:0] oInstruction,
  input  logic                  iLoadStart,
  input  logic [ADDR_WIDTH-1:0] iLoadBase,
  input  logic                  iLoadValid,
  input  logic [7:0]            iLoadByte,
  input  logic                  iLoadLast,
  output logic                  oLoadReady,
  output logic                  oHold,
  output logic                  oLoadDone,
  output logic                  oLoadErr,
`ifdef PROGMEM_PARITY_EN
  output logic                  oParityErr,
`endif
  output logic [ADDR_WIDTH:0]   oLoadCount
);

  localparam int NBYTES = (INSN_WIDTH + 7) / 8;
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
`ifdef PROGMEM_PARITY_EN
  localparam int MEMW = INSN_WIDTH + 1;
`else
  localparam int MEMW = INSN_WIDTH;
`endif
  localparam logic [INSN_WIDTH-1:0] NOP_INSN = INSN_WIDTH'(NOP_WORD);

  load_state_e             state_r, state_s;
  logic [ADDR_WIDTH:0]     ptr_r, count_r;
  logic                    err_r, done_r, ready_r, hold_r, last_r;
  logic [INSN_WIDTH-1:0]   inst_r;
  logic [MEMW-1:0]         mem_r [DEPTH];

  logic                    accept_s, word_done_s, init_s, done_s, drop_s, commit_s;
  logic                    write_s, overflow_s, in_range_s;
  logic [NBYTES*8-1:0]     asm_word_s;
  logic [MEMW-1:0]         wdata_s, rdata_s;

  assign accept_s = ready_r & iLoadValid;

  prog_mem_assembler #(.NBYTES(NBYTES)) u_asm (
    .clk      (Clock),
    .rst_n    (Reset),
    .clear    (init_s | drop_s),
    .shift_en (accept_s),
    .din      (iLoadByte),
    .word     (asm_word_s),
    .complete (word_done_s)
  );

  generate
    if (NBYTES * 8 > INSN_WIDTH) begin : g_pad
      logic unused_pad_s;
      assign unused_pad_s = ^asm_word_s[NBYTES*8-1:INSN_WIDTH];
    end
  endgenerate

  // Loader next-state logic; a restart request always lets a pending commit finish first.
  always_comb begin
    state_s  = state_r;
    init_s   = 1'b0;
    done_s   = 1'b0;
    drop_s   = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (iLoadStart) begin
          init_s  = 1'b1;
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (iLoadStart) begin
          init_s  = 1'b1;
          state_s = ST_LOAD;
        end else if (accept_s && word_done_s) begin
          state_s = ST_COMMIT;
        end else if (accept_s && iLoadLast) begin
          drop_s  = 1'b1;
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_COMMIT: begin
        commit_s = 1'b1;
        if (iLoadStart) begin
          init_s  = 1'b1;
          state_s = ST_LOAD;
        end else if (last_r) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_LOAD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Pointer MSB set means the load has run past the last word; it then saturates.
  assign write_s    = commit_s & ~ptr_r[ADDR_WIDTH];
  assign overflow_s = commit_s &  ptr_r[ADDR_WIDTH];

`ifdef PROGMEM_PARITY_EN
  assign wdata_s = {even_parity(64'(asm_word_s[INSN_WIDTH-1:0])), asm_word_s[INSN_WIDTH-1:0]};
`else
  assign wdata_s = asm_word_s[INSN_WIDTH-1:0];
`endif

  // Loader state, pointer and status registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      count_r <= '0;
      err_r   <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b0;
      hold_r  <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= done_s;
      ready_r <= (state_s == ST_LOAD);
      hold_r  <= (state_s != ST_IDLE);
      if (accept_s && word_done_s) begin
        last_r <= iLoadLast;
      end
      if (init_s) begin
        ptr_r   <= {1'b0, iLoadBase};
        count_r <= '0;
        err_r   <= 1'b0;
      end else begin
        if (write_s) begin
          ptr_r   <= ptr_r + (ADDR_WIDTH+1)'(1);
          count_r <= count_r + (ADDR_WIDTH+1)'(1);
        end
        err_r <= err_r | drop_s | overflow_s;
      end
    end
  end

  // Storage array: not reset, so committed words survive a reset.
  always_ff @(posedge Clock) begin
    if (write_s) begin
      mem_r[ptr_r[ADDR_WIDTH-1:0]] <= wdata_s;
    end
  end

  assign in_range_s = ({16'd0, iAddress} < 32'(DEPTH));
  assign rdata_s    = mem_r[iAddress[ADDR_WIDTH-1:0]];

`ifdef PROGMEM_PARITY_EN
  logic par_err_r;
  // Fetch register; parity failures substitute a NOP and latch the error flag.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      inst_r    <= NOP_INSN;
      par_err_r <= 1'b0;
    end else if (hold_r || !in_range_s) begin
      inst_r <= NOP_INSN;
    end else if (even_parity(64'(rdata_s)) != 1'b0) begin
      inst_r    <= NOP_INSN;
      par_err_r <= 1'b1;
    end else begin
      inst_r <= rdata_s[INSN_WIDTH-1:0];
    end
  end
  assign oParityErr = par_err_r;
`else
  // Fetch register; old data is returned when fetch and commit hit the same word.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      inst_r <= NOP_INSN;
    end else if (hold_r || !in_range_s) begin
      inst_r <= NOP_INSN;
    end else begin
      inst_r <= rdata_s;
    end
  end
`endif

  assign oInstruction = inst_r;
  assign oLoadReady   = ready_r;
  assign oHold        = hold_r;
  assign oLoadDone    = done_r;
  assign oLoadErr     = err_r;
  assign oLoadCount   = count_r;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Scoreboard bench for prog_mem_loader: random loads against a word-level memory model.
module tb_prog_mem_loader;

  localparam logic [27:0] NOP = 28'h0000FA0;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] iAddress = 16'd0;
  logic [27:0] oInstruction;
  logic        iLoadStart = 1'b0;
  logic [7:0]  iLoadBase = 8'd0;
  logic        iLoadValid = 1'b0;
  logic [7:0]  iLoadByte = 8'd0;
  logic        iLoadLast = 1'b0;
  logic        oLoadReady, oHold, oLoadDone, oLoadErr;
  logic [8:0]  oLoadCount;
`ifdef PROGMEM_PARITY_EN
  logic        oParityErr;
`endif

  prog_mem_loader dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iAddress     (iAddress),
    .oInstruction (oInstruction),
    .iLoadStart   (iLoadStart),
    .iLoadBase    (iLoadBase),
    .iLoadValid   (iLoadValid),
    .iLoadByte    (iLoadByte),
    .iLoadLast    (iLoadLast),
    .oLoadReady   (oLoadReady),
    .oHold        (oHold),
    .oLoadDone    (oLoadDone),
    .oLoadErr     (oLoadErr),
`ifdef PROGMEM_PARITY_EN
    .oParityErr   (oParityErr),
`endif
    .oLoadCount   (oLoadCount)
  );

  always #5 Clock = ~Clock;

  typedef logic [7:0] bytes_t [$];

  int          n_total = 0;
  int          n_pass  = 0;
  logic        fetch_req = 1'b0;
  logic [27:0] fetch_q [$];
  logic [9:0]  done_q [$];
  logic [27:0] mem_m [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Monitor: pops expectations for each registered fetch and each load-done pulse.
  initial begin
    logic        req;
    logic [27:0] ef;
    logic [9:0]  ed;
    forever begin
      @(posedge Clock);
      req = fetch_req;
      #1;
      if (req) begin
        if (fetch_q.size() == 0) fail_now("fetch_underflow");
        else begin
          ef = fetch_q.pop_front();
          check("fetch", {4'd0, oInstruction}, {4'd0, ef});
        end
      end
      if (oLoadDone) begin
        if (done_q.size() == 0) fail_now("unexpected_done");
        else begin
          ed = done_q.pop_front();
          check("done_err", {31'd0, oLoadErr}, {31'd0, ed[9]});
          check("done_count", {23'd0, oLoadCount}, {23'd0, ed[8:0]});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic fetch(input int a, input logic [27:0] e);
    iAddress  = 16'(a);
    fetch_req = 1'b1;
    fetch_q.push_back(e);
    @(negedge Clock);
    fetch_req = 1'b0;
  endtask

  task automatic fetch_known(input int a);
    if (a >= 256) fetch(a, NOP);
    else if (mem_m.exists(a)) fetch(a, mem_m[a]);
  endtask

  // Reference: whole words land at consecutive addresses, out-of-range words and leftovers flag error.
  task automatic model_load(input int base, input bytes_t q);
    int nw   = q.size() / 4;
    int cnt  = 0;
    logic err = (q.size() % 4) != 0;
    for (int k = 0; k < nw; k++) begin
      logic [31:0] w = {q[4*k], q[4*k+1], q[4*k+2], q[4*k+3]};
      if (base + k < 256) begin
        mem_m[base + k] = w[27:0];
        cnt++;
      end else err = 1'b1;
    end
    done_q.push_back({err, 9'(cnt)});
  endtask

  task automatic start_load(input int base);
    iLoadStart = 1'b1;
    iLoadBase  = 8'(base);
    @(negedge Clock);
    iLoadStart = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    iLoadValid = 1'b1;
    iLoadByte  = b;
    iLoadLast  = last;
    while (!oLoadReady && n < 100) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 100) check("ready_timeout", {31'd0, oLoadReady}, 32'd1);
    @(negedge Clock);
    iLoadValid = 1'b0;
    iLoadLast  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (oHold && n < 100) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 100) check("idle_timeout", {31'd0, oHold}, 32'd0);
    @(negedge Clock);
  endtask

  task automatic run_load(input int base, input bytes_t q);
    model_load(base, q);
    start_load(base);
    for (int i = 0; i < q.size(); i++) begin
      repeat ($urandom_range(0, 2)) @(negedge Clock);
      send_byte(q[i], i == q.size() - 1);
    end
    wait_idle();
  endtask

  function automatic bytes_t rand_bytes(input int n);
    bytes_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  initial begin
    bytes_t q;
    repeat (3) @(negedge Clock);
    check("rst_insn", {4'd0, oInstruction}, {4'd0, NOP});
    check("rst_hold", {31'd0, oHold}, 32'd0);
    check("rst_ready", {31'd0, oLoadReady}, 32'd0);
    check("rst_count", {23'd0, oLoadCount}, 32'd0);
    check("rst_done_err", {30'd0, oLoadDone, oLoadErr}, 32'd0);
    Reset = 1'b1;
    @(negedge Clock);

    q = '{8'h0A, 8'hBC, 8'hDE, 8'hF0, 8'h01, 8'h23, 8'h45, 8'h67};
    run_load(5, q);
    fetch(6, 28'h1234567);
    fetch(5, 28'hABCDEF0);
    check("count_after_two", {23'd0, oLoadCount}, 32'd2);
    fetch(16'h0100, NOP);
    fetch(16'hFFFF, NOP);

    run_load(9, rand_bytes(4));
    fetch_known(9);
    run_load(9, rand_bytes(2));
    check("partial_err", {31'd0, oLoadErr}, 32'd1);
    check("partial_count", {23'd0, oLoadCount}, 32'd0);
    fetch_known(9);

    q = rand_bytes(4);
    model_load(30, q);
    start_load(30);
    send_byte(q[0], 1'b0);
    check("hold_during_load", {31'd0, oHold}, 32'd1);
    fetch(5, NOP);
    for (int i = 1; i < 4; i++) send_byte(q[i], i == 3);
    wait_idle();
    fetch_known(30);

    run_load(255, rand_bytes(8));
    check("ovf_err", {31'd0, oLoadErr}, 32'd1);
    check("ovf_count", {23'd0, oLoadCount}, 32'd1);
    fetch_known(255);

    start_load(5);
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b0);
    Reset = 1'b0;
    #1;
    check("midrst_hold", {31'd0, oHold}, 32'd0);
    check("midrst_ready", {31'd0, oLoadReady}, 32'd0);
    check("midrst_count_err", {22'd0, oLoadErr, oLoadCount}, 32'd0);
    check("midrst_insn", {4'd0, oInstruction}, {4'd0, NOP});
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    fetch_known(5);
    fetch_known(6);
    fetch_known(30);

    for (int it = 0; it < 8; it++) begin
      int base = $urandom_range(0, 250);
      int nb   = $urandom_range(1, 12);
      run_load(base, rand_bytes(nb));
      for (int k = 0; k < nb / 4; k++) fetch_known(base + k);
      fetch($urandom_range(256, 65535), NOP);
      fetch_known($urandom_range(0, 255));
    end

`ifdef PROGMEM_PARITY_EN
    run_load(5, rand_bytes(4));
    dut.mem_r[5][0] = ~dut.mem_r[5][0];
    mem_m.delete(5);
    fetch(5, NOP);
    check("parity_err", {31'd0, oParityErr}, 32'd1);
`endif

    repeat (3) @(negedge Clock);
    check("done_q_drained", done_q.size(), 32'd0);
    check("fetch_q_drained", fetch_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
